// File: rtl/opti_sos_sched.sv
// opti_sos_sched: cascade sequencer that time-shares one SOS section engine.
// A sample is accepted in IDLE, then sent through NUM_SOS engine passes in order.
// Each pass feeds the engine result back as the input to the next section.
// The final result is offered on a valid/ready output port.
// Optional feature: define OPTI_SOS_SCHED_TIMEOUT_EN to add the engine-hang watchdog.
// The watchdog adds the err_timeout and clr_err ports.
module opti_sos_sched #(
    parameter int unsigned NUM_SOS = 4,
    parameter int unsigned DW      = 24,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] eng_data_in,
    output logic          eng_valid_in,
    output logic [1:0]    eng_sos_idx,
    input  logic [DW-1:0] eng_data_out,
    input  logic          eng_valid_out,
    output logic [1:0]    stage_idx,
`ifdef OPTI_SOS_SCHED_TIMEOUT_EN
    output logic          busy,
    output logic          err_timeout,
    input  logic          clr_err
`else
    output logic          busy
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [1:0] LAST_STAGE = 2'(NUM_SOS - 1);

    // Reject unsupported cascade depths and a watchdog too short for any engine.
    if (NUM_SOS == 0 || NUM_SOS > 4 || TIMEOUT < 2) begin : g_bad_cfg
        $error("opti_sos_sched: NUM_SOS must be 1..4 and TIMEOUT must be at least 2");
    end

    logic [1:0]    state_q, state_d;
    logic [1:0]    stage_q, stage_d;
    logic [DW-1:0] acc_q, acc_d;
    // Separate issue register so eng_data_in holds while acc takes a result in WAIT.
    logic [DW-1:0] eng_data_q, eng_data_d;

`ifdef OPTI_SOS_SCHED_TIMEOUT_EN
    localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          err_q, err_d;
    logic          timeout_hit;
`endif

    // Next-state logic for the sequencer FSM and its datapath registers.
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        acc_d      = acc_q;
        eng_data_d = eng_data_q;
`ifdef OPTI_SOS_SCHED_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        timeout_hit = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    acc_d      = s_data;
                    eng_data_d = s_data;
                    stage_d    = 2'd0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef OPTI_SOS_SCHED_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (eng_valid_out) begin
                    acc_d = eng_data_out;
                    if (stage_q == LAST_STAGE) begin
                        state_d = S_OUT;
                    end else begin
                        stage_d    = stage_q + 2'd1;
                        eng_data_d = eng_data_out;
                        state_d    = S_ISSUE;
                    end
                end
`ifdef OPTI_SOS_SCHED_TIMEOUT_EN
                // Counter holds (elapsed WAIT cycles - 1); the last allowed cycle drops the sample.
                else if (wait_cnt_q == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
`endif
            end
            S_OUT: begin
                if (m_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef OPTI_SOS_SCHED_TIMEOUT_EN
    // Sticky error flag: a new timeout takes priority over a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (timeout_hit) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    // Watchdog state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err_timeout = err_q;
`endif

    // Sequencer state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            stage_q    <= 2'd0;
            acc_q      <= '0;
            eng_data_q <= '0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            acc_q      <= acc_d;
            eng_data_q <= eng_data_d;
        end
    end

    assign s_ready      = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign eng_valid_in = (state_q == S_ISSUE);
    assign m_valid      = (state_q == S_OUT);
    assign m_data       = acc_q;
    assign eng_data_in  = eng_data_q;
    assign eng_sos_idx  = stage_q;
    assign stage_idx    = stage_q;

endmodule

// File: tb/tb_opti_sos_sched.sv
// tb_opti_sos_sched: self-checking bench for opti_sos_sched.
// The engine model is a 15-cycle delay that returns its input plus one.
// Define OPTI_SOS_SCHED_TIMEOUT_EN to also exercise the watchdog.
module tb_opti_sos_sched;

    localparam int NUM_SOS = 4;
    localparam int DW      = 24;
    localparam int L       = 15;
    localparam int LAT     = 1 + NUM_SOS * (L + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] eng_data_in;
    logic          eng_valid_in;
    logic [1:0]    eng_sos_idx;
    logic [DW-1:0] eng_data_out;
    logic          eng_valid_out;
    logic [1:0]    stage_idx;
    logic          busy;
`ifdef OPTI_SOS_SCHED_TIMEOUT_EN
    logic          err_timeout;
    logic          clr_err = 1'b0;
`endif

    // Engine model state and stray-pulse injection.
    logic          mdl_vo = 1'b0;
    logic [DW-1:0] mdl_data = '0;
    logic [DW-1:0] mdl_buf = '0;
    logic          mdl_pend = 1'b0;
    int            mdl_cnt = 0;
    logic          eng_mute = 1'b0;
    logic          inj_vo = 1'b0;
    logic [DW-1:0] inj_data = '0;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_q[$];

    assign eng_valid_out = mdl_vo | inj_vo;
    assign eng_data_out  = inj_vo ? inj_data : mdl_data;

    opti_sos_sched #(
        .NUM_SOS (NUM_SOS),
        .DW      (DW),
        .TIMEOUT (63)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .eng_data_in   (eng_data_in),
        .eng_valid_in  (eng_valid_in),
        .eng_sos_idx   (eng_sos_idx),
        .eng_data_out  (eng_data_out),
        .eng_valid_out (eng_valid_out),
        .stage_idx     (stage_idx),
`ifdef OPTI_SOS_SCHED_TIMEOUT_EN
        .busy          (busy),
        .err_timeout   (err_timeout),
        .clr_err       (clr_err)
`else
        .busy          (busy)
`endif
    );

    initial forever #5 clk = ~clk;

    // Engine model: result = input + 1, valid L cycles after the issue cycle.
    always @(posedge clk) begin
        mdl_vo <= 1'b0;
        if (mdl_pend) begin
            if (mdl_cnt == 1) begin
                mdl_vo   <= !eng_mute;
                mdl_data <= mdl_buf;
                mdl_pend <= 1'b0;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
        if (eng_valid_in) begin
            mdl_pend <= 1'b1;
            mdl_cnt  <= L - 1;
            mdl_buf  <= eng_data_in + 24'd1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one sample from IDLE and observes until m_valid (no checking here).
    task automatic run_one(input logic [DW-1:0] din, output logic [DW-1:0] dout,
                           output int lat, output int nissue, output logic [7:0] idx_pack,
                           output bit got);
        got = 0; lat = 0; nissue = 0; idx_pack = '0; dout = '0;
        s_data  = din;
        s_valid = 1'b1;
        exp_q.push_back(din + 24'(NUM_SOS));
        tick();
        s_valid = 1'b0;
        for (int c = 1; c < 300; c++) begin
            if (eng_valid_in) begin
                if (nissue < 4) idx_pack[2*nissue +: 2] = eng_sos_idx;
                nissue++;
            end
            if (m_valid) begin
                got = 1; lat = c; dout = m_data;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        n_cmp++;
        if ({s_ready, busy, m_valid, eng_valid_in} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b required 1000", {s_ready, busy, m_valid, eng_valid_in});
        end
        n_cmp++;
        if ({m_data, eng_data_in, eng_sos_idx, stage_idx} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got m_data=%h eng_data_in=%h idx=%0d stage=%0d required 0",
                     m_data, eng_data_in, eng_sos_idx, stage_idx);
        end
`ifdef OPTI_SOS_SCHED_TIMEOUT_EN
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_err: got %b required 0", err_timeout);
        end
`endif
    endtask

    task automatic test_basic();
        logic [DW-1:0] d, e;
        int lat, n;
        logic [7:0] idx;
        bit got;
        m_ready = 1'b0;
        run_one(24'd100, d, lat, n, idx, got);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL basic_mvalid: m_valid not seen, required by cycle %0d", LAT);
        end
        n_cmp++;
        if (d !== e || d !== 24'd104) begin
            n_bad++;
            $display("FAIL basic_data: got %0d required %0d", d, 104);
        end
        n_cmp++;
        if (lat !== LAT) begin
            n_bad++;
            $display("FAIL basic_latency: got cycle %0d required %0d", lat, LAT);
        end
        n_cmp++;
        if (n !== NUM_SOS) begin
            n_bad++;
            $display("FAIL basic_issue_count: got %0d required %0d", n, NUM_SOS);
        end
        n_cmp++;
        if (idx !== 8'b11_10_01_00) begin
            n_bad++;
            $display("FAIL basic_sos_idx: got %b required 11100100", idx);
        end
    endtask

    // Entered while still in OUT with m_ready low.
    task automatic test_backpressure();
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (m_valid !== 1'b1 || m_data !== 24'd104 || s_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_out: cycle %0d got v=%b d=%0d rdy=%b required 1/104/0",
                         i, m_valid, m_data, s_ready);
            end
        end
        m_ready = 1'b1;
        tick();
        n_cmp++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL release_idle: got rdy=%b v=%b busy=%b required 1/0/0",
                     s_ready, m_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] samples[2];
        logic [DW-1:0] e;
        int sent = 0, recv = 0, issues = 0;
        bit accept;
        samples[0] = 24'h7FFFFF;
        samples[1] = 24'h800000;
        m_ready = 1'b1;
        s_data  = samples[0];
        s_valid = 1'b1;
        for (int c = 0; c < 400 && recv < 2; c++) begin
            if (eng_valid_in) issues++;
            if (m_valid && m_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
                n_cmp++;
                if (m_data !== e) begin
                    n_bad++;
                    $display("FAIL b2b_data[%0d]: got %h required %h", recv, m_data, e);
                end
                recv++;
            end
            accept = s_valid && s_ready;
            if (accept) exp_q.push_back(s_data + 24'(NUM_SOS));
            tick();
            if (accept) begin
                sent++;
                if (sent < 2) s_data = samples[sent];
                else s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        n_cmp++;
        if (recv !== 2) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d outputs required 2", recv);
        end
        n_cmp++;
        if (issues !== 2 * NUM_SOS) begin
            n_bad++;
            $display("FAIL b2b_issues: got %0d pulses required %0d", issues, 2 * NUM_SOS);
        end
    endtask

    task automatic test_stray();
        logic [DW-1:0] e;
        bit got = 0;
        tick();
        inj_data = 24'h123456;
        inj_vo   = 1'b1;
        tick();
        inj_vo = 1'b0;
        n_cmp++;
        if (s_ready !== 1'b1 || m_data !== 24'h800004) begin
            n_bad++;
            $display("FAIL stray_idle: got rdy=%b m_data=%h required 1/800004", s_ready, m_data);
        end
        s_data  = 24'd10;
        s_valid = 1'b1;
        exp_q.push_back(24'd14);
        tick();
        s_valid = 1'b0;
        n_cmp++;
        if (eng_valid_in !== 1'b1) begin
            n_bad++;
            $display("FAIL stray_issue_state: got eng_valid_in=%b required 1", eng_valid_in);
        end
        inj_data = 24'hABCDEF;
        inj_vo   = 1'b1;
        tick();
        inj_vo = 1'b0;
        n_cmp++;
        if (m_data !== 24'd10 || stage_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL stray_issue_acc: got m_data=%h stage=%0d required 00000a/0",
                     m_data, stage_idx);
        end
        for (int c = 0; c < 200; c++) begin
            if (m_valid) begin got = 1; break; end
            tick();
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        n_cmp++;
        if (!got || m_data !== e) begin
            n_bad++;
            $display("FAIL stray_result: got seen=%0d m_data=%0d required 1/%0d", got, m_data, e);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        logic [DW-1:0] d, e;
        int lat, n;
        logic [7:0] idx;
        bit got, found = 0;
        s_data  = 24'd50;
        s_valid = 1'b1;
        exp_q.push_back(24'd54);
        tick();
        s_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (eng_valid_in && eng_sos_idx == 2'd2) begin found = 1; break; end
            tick();
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL midrst_stage2: stage 2 issue not seen, required");
        end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        n_cmp++;
        if ({s_ready, busy, m_valid, eng_valid_in} !== 4'b1000 ||
            {m_data, eng_data_in, eng_sos_idx, stage_idx} !== '0) begin
            n_bad++;
            $display("FAIL midrst_values: got rdy=%b busy=%b v=%b ev=%b d=%h ed=%h i=%0d s=%0d required reset values",
                     s_ready, busy, m_valid, eng_valid_in, m_data, eng_data_in, eng_sos_idx, stage_idx);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++;
            if (m_valid !== 1'b0 || busy !== 1'b0 || m_data !== 24'd0) begin
                n_bad++;
                $display("FAIL midrst_late: cycle %0d got v=%b busy=%b d=%h required 0/0/0",
                         c, m_valid, busy, m_data);
            end
        end
        m_ready = 1'b1;
        run_one(24'd5, d, lat, n, idx, got);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        n_cmp++;
        if (!got || d !== e || d !== 24'd9) begin
            n_bad++;
            $display("FAIL midrst_next: got seen=%0d data=%0d required 1/9", got, d);
        end
        tick();
    endtask

`ifdef OPTI_SOS_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int mv = 0;
        eng_mute = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            clr_err = (pass == 0);
            s_data  = 24'd77;
            s_valid = 1'b1;
            tick();
            s_valid = 1'b0;
            for (int c = 0; c < 63; c++) begin
                if (m_valid) mv++;
                tick();
            end
            n_cmp++;
            if (busy !== 1'b1 || err_timeout !== 1'b0) begin
                n_bad++;
                $display("FAIL to_before[%0d]: got busy=%b err=%b required 1/0", pass, busy, err_timeout);
            end
            tick();
            n_cmp++;
            if (err_timeout !== 1'b1 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL to_fire[%0d]: got err=%b rdy=%b v=%b required 1/1/0",
                         pass, err_timeout, s_ready, m_valid);
            end
            if (pass == 1) begin
                repeat (3) tick();
                n_cmp++;
                if (err_timeout !== 1'b1) begin
                    n_bad++;
                    $display("FAIL to_sticky: got %b required 1", err_timeout);
                end
                clr_err = 1'b1;
            end
            tick();
            clr_err = 1'b0;
            n_cmp++;
            if (err_timeout !== 1'b0) begin
                n_bad++;
                $display("FAIL to_clear[%0d]: got %b required 0", pass, err_timeout);
            end
        end
        n_cmp++;
        if (mv !== 0) begin
            n_bad++;
            $display("FAIL to_no_output: got %0d m_valid cycles required 0", mv);
        end
        repeat (20) tick();
        eng_mute = 1'b0;
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_stray();
        test_reset_midflight();
`ifdef OPTI_SOS_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
